deletion_decode_ctrl: RTL and testbench



---
 rtl/deletion_decode_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_deletion_decode_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deletion_decode_ctrl.sv
// deletion_decode_ctrl: single-deletion corrector for quaternary (DNA) words.
// Collects the N-1 received symbols, derives the missing digit (gamma) and the
// syndrome target (delta), then scans insertion positions from N-1 down to 0
// one candidate per cycle and reports {index, digit, fail} on a valid/ready port.
// Optional build macro DEC_WORD_OUT_EN adds the reconstructed codeword port word_out.
module deletion_decode_ctrl #(
    parameter int N = 98,
    parameter int A = 24,
    localparam int IDX_W = $clog2(N),
    localparam int SYN_W = $clog2(4 * N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] missing_index,
    output logic [1:0]       missing_digit,
    output logic             fail,
    output logic             busy
`ifdef DEC_WORD_OUT_EN
    ,
    output logic [2*N-1:0]   word_out
`endif
);

    typedef enum logic [1:0] {LOAD, PREP, SEARCH, DONE} state_t;

    localparam logic [SYN_W:0]   MOD   = (SYN_W+1)'(4 * N);
    localparam logic [SYN_W-1:0] A_SYN = SYN_W'(A);
    localparam logic [1:0]       A_LO  = 2'(A % 4);

    // Bring a value below 2*MOD back into [0, MOD) with one conditional subtract.
    function automatic logic [SYN_W-1:0] mod_reduce(input logic [SYN_W:0] v);
        logic [SYN_W:0] r;
        r = (v >= MOD) ? v - MOD : v;
        return r[SYN_W-1:0];
    endfunction

    // (a - b) mod 4N for operands already in [0, 4N).
    function automatic logic [SYN_W-1:0] mod_sub(input logic [SYN_W-1:0] a,
                                                 input logic [SYN_W-1:0] b);
        logic [SYN_W:0] r;
        r = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + MOD - {1'b0, b};
        return r[SYN_W-1:0];
    endfunction

    state_t           state, state_nx;
    logic [1:0]       y_buf [0:N-2];
    logic [IDX_W-1:0] count;
    logic [8:0]       sum;
    logic [SYN_W-1:0] syn;
    logic [SYN_W-1:0] delta;
    logic [SYN_W-1:0] suffix;
    logic [IDX_W-1:0] j;
    logic [1:0]       gamma;
    logic [IDX_W-1:0] index_r;
    logic             fail_r;

    logic             accept;
    logic [SYN_W:0]   load_term;
    logic [SYN_W-1:0] syn_next;
    logic [SYN_W:0]   cand_term;
    logic [SYN_W-1:0] cand;
    logic             match;
    logic [IDX_W-1:0] j_prev;
    logic [1:0]       y_prev;
    logic [SYN_W-1:0] suffix_next;

    assign accept        = in_valid && in_ready;
    assign missing_index = index_r;
    assign missing_digit = gamma;
    assign fail          = fail_r;

    // Modular arithmetic for the load accumulator and the current search candidate.
    always_comb begin
        load_term   = ((SYN_W+1)'(count) + (SYN_W+1)'(1)) * (SYN_W+1)'(in_sym);
        syn_next    = mod_reduce({1'b0, syn} + load_term);
        cand_term   = ((SYN_W+1)'(j) + (SYN_W+1)'(1)) * (SYN_W+1)'(gamma);
        cand        = mod_reduce(cand_term + {1'b0, suffix});
        match       = (cand == delta);
        j_prev      = (j == '0) ? '0 : j - IDX_W'(1);
        y_prev      = y_buf[j_prev];
        suffix_next = mod_reduce({1'b0, suffix} + (SYN_W+1)'(y_prev));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != LOAD) || (count != '0);
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && count == IDX_W'(N - 2)) state_nx = PREP;
            end
            PREP:   state_nx = SEARCH;
            SEARCH: if (match || j == '0) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    // Symbol buffer; contents are only meaningful for the frame in progress.
    always_ff @(posedge clk) begin
        if (accept) y_buf[count] <= in_sym;
    end

    // Accumulation, digit/target derivation, descending search and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            sum     <= '0;
            syn     <= '0;
            gamma   <= '0;
            index_r <= '0;
            fail_r  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        sum   <= sum + 9'(in_sym);
                        syn   <= syn_next;
                        count <= count + IDX_W'(1);
                    end
                end
                PREP: begin
                    gamma  <= A_LO - sum[1:0];
                    delta  <= mod_sub(A_SYN, syn);
                    j      <= IDX_W'(N - 1);
                    suffix <= '0;
                end
                SEARCH: begin
                    if (match) begin
                        index_r <= j;
                        fail_r  <= 1'b0;
                    end else if (j == '0) begin
                        index_r <= '0;
                        fail_r  <= 1'b1;
                    end else begin
                        suffix <= suffix_next;
                        j      <= j_prev;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        sum   <= '0;
                        syn   <= '0;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DEC_WORD_OUT_EN
    logic [2*N-1:0] ext;
    logic [2*N-1:0] low_mask;
    logic [2*N-1:0] ins;
    logic [2*N-1:0] word_next;

    // Codeword rebuild: symbols below j stay, gamma lands at j, the rest shift up one slot.
    always_comb begin
        ext = '0;
        for (int i = 0; i < N - 1; i++) ext[2*i +: 2] = y_buf[i];
        low_mask  = ((2*N)'(1) << {j, 1'b0}) - (2*N)'(1);
        ins       = (2*N)'(gamma) << {j, 1'b0};
        word_next = match ? ((ext & low_mask) | ins |
                             ((ext << 2) & ~((low_mask << 2) | (2*N)'(3))))
                          : ext;
    end

    // Reconstructed word is captured when the search terminates.
    always_ff @(posedge clk) begin
        if (rst)                                      word_out <= '0;
        else if (state == SEARCH && (match || j == '0)) word_out <= word_next;
    end
`endif

endmodule

// File: tb/tb_deletion_decode_ctrl.sv
// Bench for deletion_decode_ctrl: a small N=8/A=0 instance for directed cases
// and a default N=98/A=24 instance for randomized codewords. Results are
// compared with a reference that tries every insertion position directly.
module tb_deletion_decode_ctrl;
    localparam int NA = 8;
    localparam int AA = 0;
    localparam int NB = 98;
    localparam int AB = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    int         sel;
    logic       d_valid, d_ready;
    logic [1:0] d_sym;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_fail, a_busy;
    logic [1:0] a_digit;
    logic [2:0] a_idx;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_fail, b_busy;
    logic [1:0] b_digit;
    logic [6:0] b_idx;
`ifdef DEC_WORD_OUT_EN
    logic [2*NA-1:0] a_word;
    logic [2*NB-1:0] b_word;
`endif

    assign a_in_valid  = d_valid && (sel == 0);
    assign a_out_ready = d_ready && (sel == 0);
    assign b_in_valid  = d_valid && (sel != 0);
    assign b_out_ready = d_ready && (sel != 0);

    deletion_decode_ctrl #(.N(NA), .A(AA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sym(d_sym), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .missing_index(a_idx), .missing_digit(a_digit), .fail(a_fail), .busy(a_busy)
`ifdef DEC_WORD_OUT_EN
        , .word_out(a_word)
`endif
    );

    deletion_decode_ctrl #(.N(NB), .A(AB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sym(d_sym), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .missing_index(b_idx), .missing_digit(b_digit), .fail(b_fail), .busy(b_busy)
`ifdef DEC_WORD_OUT_EN
        , .word_out(b_word)
`endif
    );

    logic         s_in_ready, s_out_valid, s_fail, s_busy;
    logic [6:0]   s_idx;
    logic [1:0]   s_digit;
    assign s_in_ready  = (sel == 0) ? a_in_ready  : b_in_ready;
    assign s_out_valid = (sel == 0) ? a_out_valid : b_out_valid;
    assign s_fail      = (sel == 0) ? a_fail      : b_fail;
    assign s_busy      = (sel == 0) ? a_busy      : b_busy;
    assign s_idx       = (sel == 0) ? 7'(a_idx)   : b_idx;
    assign s_digit     = (sel == 0) ? a_digit     : b_digit;
`ifdef DEC_WORD_OUT_EN
    logic [255:0] s_word;
    assign s_word = (sel == 0) ? 256'(a_word) : 256'(b_word);
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0]  idx;
        logic [31:0]  digit;
        logic [31:0]  fail;
        logic [31:0]  cand;
        logic [255:0] word;
    } res_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: try every insertion position from the top down, rebuild the
    // whole candidate word and test its weighted sum directly.
    function automatic res_t model(input int n, input int a, input int y[$]);
        res_t r;
        int   s;
        int   w;
        int   x[$];
        s = 0;
        foreach (y[i]) s += y[i];
        r.digit = 32'(((a - s) % 4 + 4) % 4);
        r.fail  = 1;
        r.idx   = 0;
        r.cand  = 32'(n);
        r.word  = '0;
        foreach (y[i]) r.word[2*i +: 2] = 2'(y[i]);
        for (int j = n - 1; j >= 0; j--) begin
            x.delete();
            for (int i = 0; i < j; i++) x.push_back(y[i]);
            x.push_back(int'(r.digit));
            for (int i = j; i < n - 1; i++) x.push_back(y[i]);
            w = 0;
            foreach (x[i]) w += (i + 1) * x[i];
            if (w % (4 * n) == a) begin
                r.fail = 0;
                r.idx  = 32'(j);
                r.cand = 32'(n - j);
                r.word = '0;
                foreach (x[i]) r.word[2*i +: 2] = 2'(x[i]);
                break;
            end
        end
        return r;
    endfunction

    task automatic check_result(input string tag, input res_t m);
        check({tag, "_idx"},   256'(s_idx),   256'(m.idx));
        check({tag, "_digit"}, 256'(s_digit), 256'(m.digit));
        check({tag, "_fail"},  256'(s_fail),  256'(m.fail));
`ifdef DEC_WORD_OUT_EN
        check({tag, "_word"},  s_word,        m.word);
`endif
    endtask

    // Feed one frame to the selected instance, then check latency, result,
    // hold behaviour in DONE and the release back to LOAD.
    task automatic run_frame(input string tag, input int y[$], input bit rnd, input int hold);
        int   n, a, cyc;
        res_t m;
        n = (sel == 0) ? NA : NB;
        a = (sel == 0) ? AA : AB;
        m = model(n, a, y);
        foreach (y[i]) begin
            if (rnd) begin
                while ($urandom_range(3) == 0) begin
                    d_valid = 1'b0;
                    d_ready = 1'($urandom_range(1));
                    step();
                end
            end
            d_valid = 1'b1;
            d_sym   = 2'(y[i]);
            check({tag, "_in_ready"}, 256'(s_in_ready), 256'(1));
            step();
        end
        d_valid = 1'b0;
        d_ready = 1'b0;
        cyc = 0;
        while (!s_out_valid && cyc < 400) begin
            step();
            cyc++;
        end
        check({tag, "_latency"}, 256'(cyc), 256'(m.cand + 1));
        check_result(tag, m);
        check({tag, "_done_in_ready"}, 256'(s_in_ready), 256'(0));
        check({tag, "_done_busy"},     256'(s_busy),     256'(1));
        for (int h = 0; h < hold; h++) begin
            d_valid = 1'b1;
            d_sym   = 2'($urandom_range(3));
            step();
            check({tag, "_hold_valid"},    256'(s_out_valid), 256'(1));
            check({tag, "_hold_in_ready"}, 256'(s_in_ready),  256'(0));
            check_result({tag, "_hold"}, m);
        end
        d_valid = 1'b0;
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        check({tag, "_rel_valid"},    256'(s_out_valid), 256'(0));
        check({tag, "_rel_in_ready"}, 256'(s_in_ready),  256'(1));
        check({tag, "_rel_busy"},     256'(s_busy),      256'(0));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  256'(s_in_ready),  256'(1));
        check({tag, "_out_valid"}, 256'(s_out_valid), 256'(0));
        check({tag, "_busy"},      256'(s_busy),      256'(0));
        check({tag, "_idx"},       256'(s_idx),       256'(0));
        check({tag, "_digit"},     256'(s_digit),     256'(0));
        check({tag, "_fail"},      256'(s_fail),      256'(0));
`ifdef DEC_WORD_OUT_EN
        check({tag, "_word"},      s_word,            256'(0));
`endif
    endtask

    initial begin
        int y1[$];
        int y2[$];
        int y3[$];
        int x[$];
        int yr[$];
        int s, w, v, del;
        bit ok;

        y1 = '{0, 0, 0, 0, 0, 0, 0};
        y2 = '{3, 0, 0, 0, 0, 3, 0};
        y3 = '{1, 0, 0, 0, 0, 0, 0};

        rst = 1'b1; sel = 0; d_valid = 1'b0; d_ready = 1'b0; d_sym = 2'b00;
        repeat (3) step();
        check_idle("reset_a");
        sel = 1;
        #1;
        check_idle("reset_b");
        rst = 1'b0;
        sel = 0;
        #1;

        // All-zero word: first candidate matches at the top position.
        run_frame("s1", y1, 1'b1, 0);
        // Interior deletion of a 2.
        run_frame("s2", y2, 1'b0, 0);
        // No position satisfies the syndrome.
        run_frame("s3", y3, 1'b0, 0);
        // Consumer stalls 10 cycles while in_valid is asserted, then next frame.
        run_frame("s4", y2, 1'b0, 10);
        run_frame("s4_next", y1, 1'b0, 0);

        // Reset after a partial frame discards it.
        for (int i = 0; i < 4; i++) begin
            d_valid = 1'b1;
            d_sym   = 2'(y2[i]);
            step();
        end
        d_valid = 1'b0;
        check("s5_busy_mid", 256'(s_busy), 256'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("s5_after_rst");
        run_frame("s5", y2, 1'b0, 0);

        // Random codewords on the default-size instance. Quaternary words under
        // this check are not always uniquely recoverable, so the reference is the
        // highest matching position, which is what the scan also returns.
        sel = 1;
        #1;
        for (int f = 0; f < 8; f++) begin
            ok = 1'b0;
            for (int t = 0; t < 100000 && !ok; t++) begin
                x.delete();
                s = 0;
                w = 0;
                for (int i = 0; i < NB; i++) begin
                    v = int'($urandom_range(3));
                    x.push_back(v);
                    s += v;
                    w += (i + 1) * v;
                end
                if (s % 4 == AB % 4 && w % (4 * NB) == AB) ok = 1'b1;
            end
            del = int'($urandom_range(NB - 1));
            yr = x;
            yr.delete(del);
            run_frame("s6", yr, 1'b1, int'($urandom_range(3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
